// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit time-multiplexed 7-segment driver.
// Digits are scanned 0..3 with a blanking gap before each one. A snapshot of
// the staged value is taken once per frame so a frame never mixes digits.
// Outputs are decoded only from registered state; no input reaches an output
// without passing through a flop.
module seg7_scan_mux #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank_en,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  dig_en,
  output logic        frame_start
);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
  localparam logic [15:0] DRIVE_LAST = 16'(SCAN_DIV - 1);

  phase_t      r_phase;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_stg_val;
  logic [3:0]  r_stg_dp;
  logic [15:0] r_disp_val;
  logic [3:0]  r_disp_dp;
  logic        r_disp_lz;

  logic        w_frame_start;
  logic [3:0]  w_nib;
  logic        w_lz_hit;

  // BCD to active-high segments; non-BCD nibbles show a dash on segment g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  // Frame boundary: first blanking cycle of digit 0.
  assign w_frame_start = (r_phase == PH_BLANK) && (r_idx == 2'd0) && (r_cnt == 16'd0);

  // Scan sequencer: BLANK_CYC dead cycles, then SCAN_DIV drive cycles per digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= PH_BLANK;
      r_idx   <= 2'd0;
      r_cnt   <= 16'd0;
    end else begin
      case (r_phase)
        PH_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt   <= 16'd0;
            r_phase <= PH_DRIVE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        PH_DRIVE: begin
          if (r_cnt == DRIVE_LAST) begin
            r_cnt   <= 16'd0;
            r_phase <= PH_BLANK;
            r_idx   <= r_idx + 2'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_phase <= PH_BLANK;
          r_cnt   <= 16'd0;
        end
      endcase
    end
  end

  // Staging register follows the input whenever it is marked valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stg_val <= 16'd0;
      r_stg_dp  <= 4'd0;
    end else if (value_valid) begin
      r_stg_val <= value_in;
      r_stg_dp  <= dp_in;
    end else begin
      r_stg_val <= r_stg_val;
      r_stg_dp  <= r_stg_dp;
    end
  end

  // Per-frame snapshot; a value arriving on the frame boundary bypasses staging.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp_val <= 16'd0;
      r_disp_dp  <= 4'd0;
      r_disp_lz  <= 1'b0;
    end else if (w_frame_start) begin
      r_disp_val <= value_valid ? value_in : r_stg_val;
      r_disp_dp  <= value_valid ? dp_in : r_stg_dp;
      r_disp_lz  <= lz_blank_en;
    end else begin
      r_disp_val <= r_disp_val;
      r_disp_dp  <= r_disp_dp;
      r_disp_lz  <= r_disp_lz;
    end
  end

  // Select the current digit's nibble and decide whether it is a leading zero.
  always_comb begin
    w_nib    = 4'd0;
    w_lz_hit = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib    = r_disp_val[3:0];
        w_lz_hit = 1'b0;
      end
      2'd1: begin
        w_nib    = r_disp_val[7:4];
        w_lz_hit = (r_disp_val[15:4] == 12'd0);
      end
      2'd2: begin
        w_nib    = r_disp_val[11:8];
        w_lz_hit = (r_disp_val[15:8] == 8'd0);
      end
      2'd3: begin
        w_nib    = r_disp_val[15:12];
        w_lz_hit = (r_disp_val[15:12] == 4'd0);
      end
      default: begin
        w_nib    = 4'd0;
        w_lz_hit = 1'b0;
      end
    endcase
  end

  // Output decode: everything dark while blanking, current digit while driving.
  always_comb begin
    seg_out     = 7'd0;
    dp_out      = 1'b0;
    dig_en      = 4'd0;
    frame_start = w_frame_start;
    if (r_phase == PH_DRIVE) begin
      dig_en  = 4'b0001 << r_idx;
      dp_out  = r_disp_dp[r_idx];
      seg_out = (r_disp_lz && w_lz_hit) ? 7'd0 : seg_decode(w_nib);
    end else begin
      seg_out = 7'd0;
      dp_out  = 1'b0;
      dig_en  = 4'd0;
    end
  end

endmodule
